// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: captures a 14-bit binary value, converts it to BCD with a
// sequential double-dabble engine, and time-multiplexes the digits. Optional macro: FND_LZ_BLANK_EN.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_number,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [2:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_en
);

  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [13:0] BCD_MAX = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t             state;
  logic               busy;
  logic               overflow;
  logic               clamp;
  logic [3:0]         iter;
  logic [13:0]        shift;
  logic [15:0]        acc;
  logic [15:0]        display;
  logic [PRESC_W-1:0] presc;
  logic [1:0]         index;
  logic               run;

  // Saturate the input to the largest value four BCD digits can show.
  function automatic logic [13:0] sat_9999(input logic [13:0] v);
    sat_9999 = (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  // Add 3 to every nibble >= 5; cannot carry across nibbles since the value stays <= 9999.
  function automatic logic [15:0] add3_fix(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int n = 0; n < 4; n++) begin
      if (v[4*n +: 4] >= 4'd5)
        r[4*n +: 4] = v[4*n +: 4] + 4'd3;
    end
    add3_fix = r;
  endfunction

  // Conversion FSM: one shift-add-3 iteration per CONV cycle, then commit to the display.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      display  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load) begin
            shift <= sat_9999(i_number);
            clamp <= (i_number > BCD_MAX);
            acc   <= 16'd0;
            iter  <= 4'd0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          {acc, shift} <= {add3_fix(acc), shift} << 1;
          iter <= iter + 4'd1;
          if (iter == LAST_ITER)
            state <= COMMIT;
        end
        COMMIT: begin
          display  <= acc;
          overflow <= clamp;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan: prescaler wrap advances the digit index.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      presc <= '0;
      index <= 2'd0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (presc == PRESC_LAST) begin
        presc <= '0;
        index <= index + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_comb begin
    o_value = 4'd0;
    case (index)
      2'd0: o_value = display[3:0];
      2'd1: o_value = display[7:4];
      2'd2: o_value = display[11:8];
      2'd3: o_value = display[15:12];
      default: o_value = 4'd0;
    endcase
  end

`ifdef FND_LZ_BLANK_EN
  always_comb begin
    o_en = 1'b0;
    case (index)
      2'd0: o_en = run;
      2'd1: o_en = run & (|display[15:4]);
      2'd2: o_en = run & (|display[15:8]);
      2'd3: o_en = run & (|display[15:12]);
      default: o_en = 1'b0;
    endcase
  end
`else
  assign o_en = run;
`endif

  assign o_digitSelect = {1'b0, index};
  assign o_busy        = busy;
  assign o_overflow    = overflow;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: directed and random loads against an integer-level model.
module tb_fnd_scan_controller;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] number = '0;
  logic        load = 1'b0;
  logic        busy, overflow, en;
  logic [2:0]  dsel;
  logic [3:0]  value;

  int total = 0;
  int bad = 0;

  // Reference model state (decimal integers, cycle counts)
  int m_disp = 0;
  int m_ovf = 0;
  int m_busy_left = 0;
  int m_pend = 0;
  int m_pclamp = 0;
  int m_ticks = 0;
  int m_run = 0;
  int p10[4] = '{1, 10, 100, 1000};

  fnd_scan_controller #(.SCAN_DIV(SD)) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_number(number),
    .i_load(load),
    .o_busy(busy),
    .o_overflow(overflow),
    .o_digitSelect(dsel),
    .o_value(value),
    .o_en(en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_disp = 0; m_ovf = 0; m_busy_left = 0; m_ticks = 0; m_run = 0;
    end else begin
      m_run = 1;
      m_ticks = (m_ticks + 1) % (4 * SD);
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_disp = m_pend;
          m_ovf = m_pclamp;
        end
      end else if (load) begin
        m_busy_left = 15;
        m_pend = (int'(number) > 9999) ? 9999 : int'(number);
        m_pclamp = (int'(number) > 9999) ? 1 : 0;
      end
    end
  endtask

  task automatic step();
    int idx;
    int exp_en;
    model_edge();
    @(posedge clk);
    #1;
    idx = m_ticks / SD;
`ifdef FND_LZ_BLANK_EN
    exp_en = (m_run != 0) && (idx == 0 || (m_disp / p10[idx]) != 0);
`else
    exp_en = m_run;
`endif
    chk("busy", 16'(busy), 16'(m_busy_left > 0));
    chk("overflow", 16'(overflow), 16'(m_ovf));
    chk("digit_select", 16'(dsel), 16'(idx));
    chk("value", 16'(value), 16'((m_disp / p10[idx]) % 10));
    chk("en", 16'(en), 16'(exp_en));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input int v);
    number = 14'(v);
    load = 1'b1;
    step();
    load = 1'b0;
    number = 14'($urandom_range(0, 16383));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    idle(20);                 // idle scan with zero display
    do_load(1234);
    idle(20);
    do_load(12000);           // clamps to 9999
    idle(20);
    do_load(5);
    idle(20);
    do_load(42);              // leading-zero case
    idle(20);
    do_load(3141);            // edge N
    idle(4);
    do_load(2718);            // edge N+5, ignored while busy
    idle(10);
    do_load(808);             // edge N+16, accepted
    idle(20);
    do_load(9999);
    idle(6);
    do_reset(1);              // reset at N+7 aborts conversion
    idle(3);
    do_load(7);
    idle(20);
    do_load(0);
    idle(17);
    for (int r = 0; r < 40; r++) begin
      do_load(int'($urandom_range(0, 16383)));
      idle(int'($urandom_range(0, 20)));
      if ($urandom_range(0, 9) == 0) do_reset(int'($urandom_range(1, 2)));
    end
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
